// File: rtl/lfsr_checker.sv
// Serial PRBS checker: self-syncs a local Fibonacci LFSR to the received
// stream, then free-runs it and flags/counts bit errors while locked.
module lfsr_checker #(
  parameter int N        = 4,
  parameter int TAP      = 2,
  parameter int LOCK_CNT = 8,
  parameter int LOSS_CNT = 4,
  parameter int CW       = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rx_valid,
  input  logic          rx_bit,
  input  logic          clear_count,
  output logic          locked,
  output logic          bit_err,
  output logic [CW-1:0] err_count,
  output logic [CW-1:0] bit_count
);

  localparam int FW = $clog2(N + 1);
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int LW = $clog2(LOSS_CNT + 1);

  typedef enum logic [1:0] {
    SEARCH,
    VERIFY,
    LOCKED
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  lfsr_q, lfsr_d;
  logic [FW-1:0] fill_q, fill_d;
  logic [MW-1:0] match_q, match_d;
  logic [LW-1:0] miss_q, miss_d;
  logic          bit_err_d;
  logic [CW-1:0] err_d, bits_d;
  logic [CW-1:0] err_base, bits_base;
  logic          pred;
  logic          miss;

  function automatic logic [CW-1:0] sat_inc(
    input logic [CW-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

  assign pred = lfsr_q[N-1] ^ lfsr_q[TAP];
  assign miss = rx_bit != pred;

  // clear lands before any same-cycle event
  assign err_base  = clear_count ? '0 : err_count;
  assign bits_base = clear_count ? '0 : bit_count;

  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    fill_d    = fill_q;
    match_d   = match_q;
    miss_d    = miss_q;
    bit_err_d = 1'b0;
    err_d     = err_base;
    bits_d    = bits_base;
    if (rx_valid) begin
      unique case (state_q)
        SEARCH: begin
          lfsr_d = {lfsr_q[N-2:0], rx_bit};
          fill_d = fill_q + 1'b1;
          if (fill_q == FW'(N - 1)) begin
            state_d = VERIFY;
            match_d = '0;
          end
        end
        VERIFY: begin
          lfsr_d = {lfsr_q[N-2:0], rx_bit};
          // all-zero register would "predict" a stuck-low line
          if (!miss && (lfsr_q != '0)) begin
            match_d = match_q + 1'b1;
            if (match_q == MW'(LOCK_CNT - 1)) begin
              state_d = LOCKED;
              miss_d  = '0;
            end
          end else begin
            match_d = '0;
          end
        end
        LOCKED: begin
          lfsr_d = {lfsr_q[N-2:0], pred};
          bits_d = sat_inc(bits_base);
          if (miss) begin
            bit_err_d = 1'b1;
            err_d     = sat_inc(err_base);
            miss_d    = miss_q + 1'b1;
            if (miss_q == LW'(LOSS_CNT - 1)) begin
              state_d = SEARCH;
              fill_d  = '0;
            end
          end else begin
            miss_d = '0;
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= SEARCH;
      lfsr_q    <= '0;
      fill_q    <= '0;
      match_q   <= '0;
      miss_q    <= '0;
      bit_err   <= 1'b0;
      err_count <= '0;
      bit_count <= '0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      fill_q    <= fill_d;
      match_q   <= match_d;
      miss_q    <= miss_d;
      bit_err   <= bit_err_d;
      err_count <= err_d;
      bit_count <= bits_d;
    end
  end

  assign locked = (state_q == LOCKED);

endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker: directed scenarios plus random traffic, all
// cycles scored against a sequence-level reference model.
module tb_lfsr_checker;

  localparam int N        = 4;
  localparam int TAP      = 2;
  localparam int LOCK_CNT = 8;
  localparam int LOSS_CNT = 4;
  localparam int CW       = 8;
  localparam int MAXC     = (1 << CW) - 1;
  localparam int SRCH = 0, VER = 1, LCK = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rx_valid = 1'b0;
  logic          rx_bit = 1'b0;
  logic          clear_count = 1'b0;
  logic          locked, bit_err;
  logic [CW-1:0] err_count, bit_count;

  lfsr_checker #(
    .N(N), .TAP(TAP), .LOCK_CNT(LOCK_CNT),
    .LOSS_CNT(LOSS_CNT), .CW(CW)
  ) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid),
    .rx_bit(rx_bit), .clear_count(clear_count),
    .locked(locked), .bit_err(bit_err),
    .err_count(err_count), .bit_count(bit_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit lk;
    bit be;
    int ec;
    int bc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int tests = 0;
  int fails = 0;

  // reference: last N accepted bits as a list, oldest first
  int m_mode, m_fill, m_streak, m_miss, m_err, m_bits;
  bit m_be;
  bit m_hist[$];

  // generator: seed bits MSB-first, then s[k+N] = s[k] ^ s[k+N-1-TAP]
  bit g_seq[$];
  int g_pos;

  function automatic bit gen_next();
    bit b;
    if (g_pos < N) begin
      b = g_seq[g_pos];
      g_pos++;
    end else begin
      b = g_seq[0] ^ g_seq[N-1-TAP];
      void'(g_seq.pop_front());
      g_seq.push_back(b);
    end
    return b;
  endfunction

  function automatic void model_reset();
    m_mode = SRCH; m_fill = 0; m_streak = 0;
    m_miss = 0; m_err = 0; m_bits = 0; m_be = 0;
    m_hist = {};
    for (int i = 0; i < N; i++) m_hist.push_back(1'b0);
  endfunction

  function automatic void hist_push(bit x);
    void'(m_hist.pop_front());
    m_hist.push_back(x);
  endfunction

  function automatic void model_step(bit v, bit b, bit clr);
    bit pred, allz;
    exp_t e;
    m_be = 0;
    if (clr) begin
      m_err = 0;
      m_bits = 0;
    end
    if (v) begin
      pred = m_hist[0] ^ m_hist[N-1-TAP];
      allz = 1;
      foreach (m_hist[i]) if (m_hist[i]) allz = 0;
      if (m_mode == SRCH) begin
        hist_push(b);
        m_fill++;
        if (m_fill == N) begin
          m_mode = VER;
          m_streak = 0;
        end
      end else if (m_mode == VER) begin
        hist_push(b);
        if (b == pred && !allz) begin
          m_streak++;
          if (m_streak == LOCK_CNT) begin
            m_mode = LCK;
            m_miss = 0;
          end
        end else m_streak = 0;
      end else begin
        hist_push(pred);
        if (m_bits < MAXC) m_bits++;
        if (b != pred) begin
          m_be = 1;
          if (m_err < MAXC) m_err++;
          m_miss++;
          if (m_miss == LOSS_CNT) begin
            m_mode = SRCH;
            m_fill = 0;
          end
        end else m_miss = 0;
      end
    end
    e.lk = (m_mode == LCK);
    e.be = m_be;
    e.ec = m_err;
    e.bc = m_bits;
    q.push_back(e);
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic cycle(bit v, bit b, bit clr);
    @(negedge clk);
    rx_valid = v;
    rx_bit = b;
    clear_count = clr;
    model_step(v, b, clr);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    reset = 1'b1;
    rx_valid = 1'b0;
    clear_count = 1'b0;
    #1;
    chk("rst_locked", locked, 0);
    chk("rst_bit_err", bit_err, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_bit_count", bit_count, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic lock_clean(string nm);
    for (int i = 1; i <= N + LOCK_CNT; i++) begin
      cycle(1, gen_next(), 0);
      if (i >= N + LOCK_CNT - 1) begin
        after_edge();
        chk(nm, locked, (i == N + LOCK_CNT) ? 1 : 0);
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        mon_e = q.pop_front();
        tests++;
        if ($isunknown({locked, bit_err, err_count, bit_count}) ||
            locked != mon_e.lk || bit_err != mon_e.be ||
            int'(err_count) != mon_e.ec ||
            int'(bit_count) != mon_e.bc) begin
          fails++;
          $display("FAIL scoreboard @%0t: got lk=%0b be=%0b ec=%0d bc=%0d expected lk=%0b be=%0b ec=%0d bc=%0d",
                   $time, locked, bit_err, err_count, bit_count,
                   mon_e.lk, mon_e.be, mon_e.ec, mon_e.bc);
        end
      end
    end
  end

  initial begin
    int burst;
    bit v, b;
    g_seq = {1'b1, 1'b0, 1'b0, 1'b1};
    g_pos = 0;
    model_reset();

    // 1: clean stream
    do_reset();
    lock_clean("s1_lock");
    repeat (100) cycle(1, gen_next(), 0);
    after_edge();
    chk("s1_bit_count", bit_count, 100);
    chk("s1_err_count", err_count, 0);

    // 2: single inverted bit
    cycle(1, ~gen_next(), 0);
    after_edge();
    chk("s2_bit_err", bit_err, 1);
    chk("s2_err_count", err_count, 1);
    chk("s2_locked", locked, 1);
    cycle(1, gen_next(), 0);
    after_edge();
    chk("s2_pulse_end", bit_err, 0);
    repeat (20) cycle(1, gen_next(), 0);
    after_edge();
    chk("s2_err_hold", err_count, 1);

    // 3: stuck-low line
    do_reset();
    repeat (64) cycle(1, 0, 0);
    after_edge();
    chk("s3_locked", locked, 0);
    chk("s3_err_count", err_count, 0);

    // 4: loss of lock and reacquire
    do_reset();
    lock_clean("s4_lock");
    for (int i = 1; i <= LOSS_CNT; i++) begin
      cycle(1, ~gen_next(), 0);
      after_edge();
      chk("s4_locked_during", locked, (i == LOSS_CNT) ? 0 : 1);
    end
    chk("s4_err_count", err_count, 4);
    lock_clean("s4_relock");
    chk("s4_err_kept", err_count, 4);

    // 5: rx_valid toggling
    do_reset();
    for (int i = 1; i <= N + LOCK_CNT; i++) begin
      cycle(1, gen_next(), 0);
      if (i >= N + LOCK_CNT - 1) begin
        after_edge();
        chk("s5_lock", locked, (i == N + LOCK_CNT) ? 1 : 0);
      end
      cycle(0, 1'($urandom), 0);
    end
    for (int i = 0; i < 100; i++) begin
      cycle(1, gen_next(), 0);
      cycle(0, 1'($urandom), 0);
    end
    after_edge();
    chk("s5_bit_count", bit_count, 100);
    chk("s5_err_count", err_count, 0);

    // 6: clear with coincident error, then reset mid-lock
    do_reset();
    lock_clean("s6_lock");
    repeat (5) cycle(1, gen_next(), 0);
    cycle(1, ~gen_next(), 1);
    after_edge();
    chk("s6_err_count", err_count, 1);
    chk("s6_bit_count", bit_count, 1);
    chk("s6_bit_err", bit_err, 1);
    do_reset();
    lock_clean("s6_relock");

    // random traffic: gaps, clears, sparse errors and bursts
    burst = 0;
    for (int i = 0; i < 3000; i++) begin
      v = ($urandom_range(0, 3) != 0);
      b = v ? gen_next() : 1'($urandom);
      if (v) begin
        if (burst > 0) begin
          b = ~b;
          burst--;
        end else if ($urandom_range(0, 29) == 0) begin
          b = ~b;
        end else if ($urandom_range(0, 199) == 0) begin
          burst = $urandom_range(2, 6);
        end
      end
      cycle(v, b, $urandom_range(0, 99) == 0);
    end

    // saturation of both counters
    do_reset();
    lock_clean("sat_lock");
    repeat (300) cycle(1, gen_next(), 0);
    for (int i = 0; i < 300; i++) begin
      cycle(1, ~gen_next(), 0);
      cycle(1, gen_next(), 0);
    end
    after_edge();
    chk("sat_bit_count", bit_count, MAXC);
    chk("sat_err_count", err_count, MAXC);
    chk("sat_locked", locked, 1);

    @(negedge clk);
    rx_valid = 1'b0;
    clear_count = 1'b0;
    repeat (3) @(negedge clk);
    chk("queue_drain", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lfsr_checker.md
# lfsr_checker

Serial pseudo-random bit-sequence checker: the receive end of the Fibonacci LFSR pattern generator. It accepts one bit per qualified cycle and self-synchronizes a local LFSR to the incoming stream. Once locked, it free-runs that LFSR and compares every received bit against it, flagging and counting bit errors. It sits at the far end of a serial link or loopback path as the pass/fail monitor for LFSR-driven link tests.

## Interface
Parameters:
- N, 4, LFSR length in bits (N >= 3)
- TAP, 2, second feedback index (0 <= TAP <= N-2). Feedback = reg[N-1] ^ reg[TAP], i.e. polynomial x^N + x^(TAP+1) + 1
- LOCK_CNT, 8, consecutive correct predictions required to declare lock
- LOSS_CNT, 4, consecutive mismatches while locked that drop lock
- CW, 16, width of err_count and bit_count

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- rx_valid  in  1  rx_bit is sampled only when high
- rx_bit  in  1  received serial bit, oldest-first (generator MSB-first order)
- clear_count  in  1  synchronous clear of err_count and bit_count
- locked  out  1  checker is synchronized
- bit_err  out  1  one-cycle pulse per mismatch while locked
- err_count  out  CW  saturating count of mismatches while locked
- bit_count  out  CW  saturating count of bits checked while locked

## Operation
- State register reg[N-1:0]. On each accepted bit it shifts left and the new bit enters reg[0]. predicted = reg[N-1] ^ reg[TAP].
- FSM states: SEARCH, VERIFY, LOCKED. Reset state is SEARCH. When rx_valid=0, state, reg and all counters hold.
- SEARCH: reg shifts in rx_bit; fill counter increments. After N accepted bits, clear the match counter and go to VERIFY.
- VERIFY: reg shifts in rx_bit.
  - Match: rx_bit == predicted and reg != 0. Increment the match counter. If this is the LOCK_CNT-th consecutive match, go to LOCKED.
  - Any mismatch, or reg == 0: clear the match counter and stay in VERIFY. The all-zero rule prevents false lock on a stuck-low line.
- LOCKED: reg shifts in predicted, never rx_bit, so a single line error does not corrupt the local LFSR.
  - Each accepted bit increments bit_count.
  - Mismatch: pulse bit_err, increment err_count and the miss counter.
  - Match: clear the miss counter.
  - When the miss counter reaches LOSS_CNT, go to SEARCH with the fill counter cleared. reg keeps its value.
- err_count and bit_count saturate at 2^CW-1 and are never wrapped. They change only in LOCKED; they hold through lock loss and reacquisition.
- clear_count: clears both counts. If a counted event occurs in the same cycle, clear is applied first and the event is then counted, so the result is 1.
- Counters and bit_err are not affected by errors seen in SEARCH or VERIFY.

## Timing
- All outputs are registered. After reset, locked=0, bit_err=0, err_count=0, bit_count=0. Reset asserted mid-lock forces these values immediately, without waiting for a clock.
- Clean stream: locked rises in the cycle after the (N+LOCK_CNT)-th accepted bit. With default parameters that is the 12th bit.
- bit_err is high in the cycle after the erroneous bit is sampled, for exactly one cycle. err_count updates on the same edge.
- Lock loss: locked falls in the cycle after the LOSS_CNT-th consecutive mismatch. That mismatch is still counted.
- Back-to-back accepted bits (rx_valid held high) are supported at full rate. Gaps of any length are allowed.
- No combinational path from inputs to outputs.

## Test plan
1. Reset, then a clean stream from the generator (N=4, TAP=2, seed 4'b1001) with rx_valid=1 continuously. Required: locked=1 the cycle after bit 12. After 100 further bits: bit_count=100, err_count=0, bit_err never pulsed.
2. While locked, invert one bit. Required: one bit_err pulse the following cycle, err_count=1, locked stays 1. Subsequent bits match with no further errors.
3. rx_bit held at 0 for 64 accepted bits. Required: locked stays 0 and err_count stays 0.
4. While locked, invert 4 consecutive bits, then resume a clean stream. Required: err_count=4 and locked=0 the cycle after the 4th inverted bit. locked returns to 1 twelve accepted bits later, and err_count is still 4.
5. Repeat scenario 1 with rx_valid toggling 1/0 every cycle. Required: identical lock point in accepted bits (12th accepted bit) and identical counts.
6. Assert clear_count in the same cycle as a locked-state mismatch. Required: err_count=1 and bit_count=1. Then assert reset mid-lock. Required: all outputs 0 with no clock edge, and lock reacquired after 12 clean bits.
